mem_ctrl: RTL

- Memory-side responder for the load/store queue's data-port request protocol, plus the instruction-fetch port.
- Serialises word, half and byte accesses onto the byte-wide RAM/IO bus.
- Arbitrates between the data and fetch ports.
- Returns read data or completion as a one-cycle ready pulse.

---
 rtl/mem_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - data/fetch port responder serialising accesses onto a byte-wide RAM/IO bus
module mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI  = 2'b11,
    parameter int         FETCH_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_rollback,
    input  logic        in_mem_ena,
    input  logic        in_mem_iswrite,
    input  logic [2:0]  in_mem_size,
    input  logic [31:0] in_mem_addr,
    input  logic [31:0] in_mem_write_data,
    output logic        out_mem_ready,
    output logic [31:0] out_mem_read_data,
    input  logic        in_fetch_ena,
    input  logic [31:0] in_fetch_addr,
    output logic        out_fetch_ready,
    output logic [31:0] out_fetch_inst,
    input  logic [7:0]  in_ram_din,
    input  logic        in_io_buffer_full,
    output logic [31:0] out_ram_addr,
    output logic        out_ram_wr,
    output logic [7:0]  out_ram_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] FETCH_LAST = (FETCH_BYTES == 1) ? 2'd0 :
                                        (FETCH_BYTES == 2) ? 2'd1 : 2'd3;

    // Index of the last byte; anything other than 1 or 2 bytes is a word.
    function automatic logic [1:0] f_last(input logic [2:0] size);
        case (size)
            3'd1:    f_last = 2'd0;
            3'd2:    f_last = 2'd1;
            default: f_last = 2'd3;
        endcase
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [1:0]  r_last;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_is_fetch;

    logic        r_dp;
    logic        r_dp_wr;
    logic [1:0]  r_dp_last;
    logic [31:0] r_dp_addr;
    logic [31:0] r_dp_data;
    logic        r_fp;
    logic [31:0] r_fp_addr;

    logic        r_mem_ready;
    logic [31:0] r_mem_rdata;
    logic        r_fetch_ready;
    logic [31:0] r_fetch_inst;

    logic        w_req_d;
    logic        w_req_f;
    logic        w_d_valid;
    logic        w_d_wr;
    logic [1:0]  w_d_last;
    logic [31:0] w_d_addr;
    logic [31:0] w_d_data;
    logic        w_f_valid;
    logic [31:0] w_f_addr;
    logic        w_arb;
    logic        w_accept_d;
    logic        w_accept_f;
    logic        w_stall;
    logic [31:0] w_wshift;

    // A live pulse competes in arbitration on the same edge it is latched.
    assign w_req_d    = in_mem_ena & ~in_rollback;
    assign w_req_f    = in_fetch_ena & ~in_rollback;
    assign w_d_valid  = r_dp | w_req_d;
    assign w_d_wr     = r_dp ? r_dp_wr   : in_mem_iswrite;
    assign w_d_last   = r_dp ? r_dp_last : f_last(in_mem_size);
    assign w_d_addr   = r_dp ? r_dp_addr : in_mem_addr;
    assign w_d_data   = r_dp ? r_dp_data : in_mem_write_data;
    assign w_f_valid  = r_fp | w_req_f;
    assign w_f_addr   = r_fp ? r_fp_addr : in_fetch_addr;
    assign w_arb      = ((r_state == S_IDLE) | (r_state == S_DONE)) & ~in_rollback;
    assign w_accept_d = w_arb & w_d_valid;
    assign w_accept_f = w_arb & ~w_d_valid & w_f_valid;

    assign w_stall  = (r_state == S_WRITE) & (r_addr[17:16] == IO_ADDR_HI) & in_io_buffer_full;
    assign w_wshift = r_wdata >> {r_cnt, 3'b000};

    assign out_ram_addr      = ((r_state == S_READ) | (r_state == S_WRITE)) ? (r_addr + {30'd0, r_cnt}) : 32'd0;
    assign out_ram_wr        = (r_state == S_WRITE) & ~w_stall;
    assign out_ram_dout      = out_ram_wr ? w_wshift[7:0] : 8'h00;
    assign out_mem_ready     = r_mem_ready;
    assign out_mem_read_data = r_mem_rdata;
    assign out_fetch_ready   = r_fetch_ready;
    assign out_fetch_inst    = r_fetch_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_last        <= 2'd0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_rdata       <= 32'd0;
            r_is_fetch    <= 1'b0;
            r_dp          <= 1'b0;
            r_dp_wr       <= 1'b0;
            r_dp_last     <= 2'd0;
            r_dp_addr     <= 32'd0;
            r_dp_data     <= 32'd0;
            r_fp          <= 1'b0;
            r_fp_addr     <= 32'd0;
            r_mem_ready   <= 1'b0;
            r_mem_rdata   <= 32'd0;
            r_fetch_ready <= 1'b0;
            r_fetch_inst  <= 32'd0;
        end else if (ena) begin
            r_mem_ready   <= 1'b0;
            r_mem_rdata   <= 32'd0;
            r_fetch_ready <= 1'b0;
            r_fetch_inst  <= 32'd0;

            // Rollback drops speculative loads and fetches; stores are architectural.
            if (in_rollback) begin
                if (!r_dp_wr) r_dp <= 1'b0;
                r_fp <= 1'b0;
            end else begin
                if (w_accept_d) begin
                    r_dp <= 1'b0;
                end else if (in_mem_ena && !r_dp) begin
                    r_dp      <= 1'b1;
                    r_dp_wr   <= in_mem_iswrite;
                    r_dp_last <= f_last(in_mem_size);
                    r_dp_addr <= in_mem_addr;
                    r_dp_data <= in_mem_write_data;
                end
                if (w_accept_f) begin
                    r_fp <= 1'b0;
                end else if (in_fetch_ena && !r_fp) begin
                    r_fp      <= 1'b1;
                    r_fp_addr <= in_fetch_addr;
                end
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE && !in_rollback) begin
                        if (r_is_fetch) begin
                            r_fetch_ready <= 1'b1;
                            r_fetch_inst  <= r_rdata;
                        end else begin
                            r_mem_ready <= 1'b1;
                            r_mem_rdata <= r_rdata;
                        end
                    end
                    r_cnt   <= 2'd0;
                    r_rdata <= 32'd0;
                    if (w_accept_d) begin
                        r_addr     <= w_d_addr;
                        r_wdata    <= w_d_data;
                        r_last     <= w_d_last;
                        r_is_fetch <= 1'b0;
                        r_state    <= w_d_wr ? S_WRITE : S_READ;
                    end else if (w_accept_f) begin
                        r_addr     <= w_f_addr;
                        r_wdata    <= 32'd0;
                        r_last     <= FETCH_LAST;
                        r_is_fetch <= 1'b1;
                        r_state    <= S_READ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (in_rollback) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rdata <= r_rdata | ({24'd0, in_ram_din} << {r_cnt, 3'b000});
                        if (r_cnt == r_last) r_state <= S_DONE;
                        else                 r_cnt   <= r_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (!w_stall) begin
                        if (r_cnt == r_last) begin
                            r_state     <= S_IDLE;
                            r_mem_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
